// File: rtl/fft_band_analyzer.sv
// Streams audio samples into a framed FFT sink, then folds the FFT output bins into
// log-spaced band magnitudes with optional peak-hold decay for the visualiser.
module fft_band_analyzer #(
    parameter int DATA_W      = 16,
    parameter int FFT_LEN     = 512,
    parameter int NUM_BANDS   = 16,
    parameter int MAG_W       = 16,
    parameter int DECAY_SHIFT = 3
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_sample_valid,
    input  logic [DATA_W-1:0]          i_sample,
    output logic                       o_sample_ready,
    output logic                       o_sink_valid,
    output logic                       o_sink_sop,
    output logic                       o_sink_eop,
    output logic [DATA_W-1:0]          o_sink_real,
    input  logic                       i_sink_ready,
    input  logic                       i_src_valid,
    input  logic                       i_src_sop,
    input  logic                       i_src_eop,
    input  logic [DATA_W-1:0]          i_src_real,
    input  logic [DATA_W-1:0]          i_src_imag,
    output logic                       o_src_ready,
    input  logic                       i_hold_en,
    input  logic                       i_err_clr,
    output logic [NUM_BANDS*MAG_W-1:0] o_bands,
    output logic                       o_frame_done,
    output logic                       o_frame_err
);

    localparam int CNT_W     = $clog2(FFT_LEN);
    localparam int HALF      = FFT_LEN / 2;
    localparam int LOG2_HALF = CNT_W - 1;
    localparam int SUM_W     = DATA_W + 1;
    localparam logic [CNT_W-1:0] LAST_BIN = CNT_W'(FFT_LEN - 1);

    // Lower bin edge of band k: floor(2^(k*log2(HALF)/NUM_BANDS)), forced strictly increasing.
    // The tiny bias keeps exact powers of two from truncating one below the integer.
    function automatic int band_edge(input int k);
        int  lo;
        int  cand;
        real ex;
        lo = 1;
        for (int j = 1; j <= k; j++) begin
            ex   = real'(j * LOG2_HALF) / real'(NUM_BANDS);
            cand = $rtoi(2.0 ** ex + 1.0e-9);
            lo   = (cand > lo + 1) ? cand : lo + 1;
        end
        return (lo > HALF) ? HALF : lo;
    endfunction

    // ---------------------------------------------------------------- sink side
    logic [CNT_W-1:0]  sink_cnt_reg;
    logic              sink_valid_reg;
    logic              sink_sop_reg;
    logic              sink_eop_reg;
    logic [DATA_W-1:0] sink_real_reg;
    logic              sample_take;

    assign o_sample_ready = !sink_valid_reg || i_sink_ready;
    assign sample_take    = i_sample_valid && o_sample_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sink_cnt_reg   <= '0;
            sink_valid_reg <= 1'b0;
            sink_sop_reg   <= 1'b0;
            sink_eop_reg   <= 1'b0;
            sink_real_reg  <= '0;
        end else if (sample_take) begin
            sink_valid_reg <= 1'b1;
            sink_real_reg  <= i_sample;
            sink_sop_reg   <= (sink_cnt_reg == '0);
            sink_eop_reg   <= (sink_cnt_reg == LAST_BIN);
            sink_cnt_reg   <= (sink_cnt_reg == LAST_BIN) ? '0 : sink_cnt_reg + 1'b1;
        end else if (i_sink_ready) begin
            sink_valid_reg <= 1'b0;
        end
    end

    assign o_sink_valid = sink_valid_reg;
    assign o_sink_sop   = sink_sop_reg;
    assign o_sink_eop   = sink_eop_reg;
    assign o_sink_real  = sink_real_reg;

    // ---------------------------------------------------------------- magnitude
    logic signed [SUM_W-1:0] re_ext;
    logic signed [SUM_W-1:0] im_ext;
    logic [SUM_W-1:0]        abs_re;
    logic [SUM_W-1:0]        abs_im;
    logic [SUM_W-1:0]        mag_max;
    logic [SUM_W-1:0]        mag_min;
    logic [SUM_W-1:0]        mag_sum;
    logic [MAG_W-1:0]        mag;

    // One extra bit so |-2^(DATA_W-1)| is representable without wrapping.
    always_comb begin
        re_ext  = {i_src_real[DATA_W-1], i_src_real};
        im_ext  = {i_src_imag[DATA_W-1], i_src_imag};
        abs_re  = re_ext[SUM_W-1] ? SUM_W'(-re_ext) : SUM_W'(re_ext);
        abs_im  = im_ext[SUM_W-1] ? SUM_W'(-im_ext) : SUM_W'(im_ext);
        mag_max = (abs_re > abs_im) ? abs_re : abs_im;
        mag_min = (abs_re > abs_im) ? abs_im : abs_re;
        mag_sum = mag_max + (mag_min >> 1);
    end

    generate
        if (MAG_W >= SUM_W) begin : g_mag_wide
            assign mag = MAG_W'(mag_sum);
        end else begin : g_mag_sat
            assign mag = (|mag_sum[SUM_W-1:MAG_W]) ? {MAG_W{1'b1}} : mag_sum[MAG_W-1:0];
        end
    endgenerate

    // ---------------------------------------------------------------- source framing
    logic [CNT_W-1:0] src_cnt_reg;
    logic [CNT_W-1:0] eff_cnt;
    logic             is_last;
    logic             acc_clr;
    logic             commit;
    logic             err_set;
    logic             frame_done_reg;
    logic             frame_err_reg;

    // A SOP beat is always bin 0, even when it arrives mid-frame.
    always_comb begin
        eff_cnt = i_src_sop ? '0 : src_cnt_reg;
        is_last = (eff_cnt == LAST_BIN);
        acc_clr = i_src_valid && (i_src_sop || i_src_eop || is_last);
        commit  = i_src_valid && i_src_eop && is_last;
        err_set = i_src_valid && ((i_src_sop && (src_cnt_reg != '0)) ||
                                  (i_src_eop && !is_last) ||
                                  (is_last && !i_src_eop));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            src_cnt_reg    <= '0;
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            if (i_src_valid) begin
                src_cnt_reg <= (i_src_eop || is_last) ? '0 : eff_cnt + 1'b1;
            end
            frame_done_reg <= commit;
            if (err_set) begin
                frame_err_reg <= 1'b1;
            end else if (i_err_clr) begin
                frame_err_reg <= 1'b0;
            end
        end
    end

    assign o_src_ready  = 1'b1;
    assign o_frame_done = frame_done_reg;
    assign o_frame_err  = frame_err_reg;

    // ---------------------------------------------------------------- per-band reduction
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANDS; gi++) begin : g_band
            localparam int LO = band_edge(gi);
            localparam int HI = band_edge(gi + 1);
            localparam logic [CNT_W-1:0] LO_BIN = CNT_W'(LO);
            localparam logic [CNT_W-1:0] HI_BIN = CNT_W'(HI);

            logic             in_band;
            logic [MAG_W-1:0] acc_reg;
            logic [MAG_W-1:0] band_reg;
            logic [MAG_W-1:0] decayed;
            logic [MAG_W-1:0] held;

            assign in_band = (eff_cnt >= LO_BIN) && (eff_cnt < HI_BIN);
            assign decayed = band_reg - (band_reg >> DECAY_SHIFT);
            assign held    = (acc_reg > decayed) ? acc_reg : decayed;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    acc_reg  <= '0;
                    band_reg <= '0;
                end else begin
                    if (acc_clr) begin
                        acc_reg <= '0;
                    end else if (i_src_valid && in_band && (mag > acc_reg)) begin
                        acc_reg <= mag;
                    end
                    // The EOP beat carries bin FFT_LEN-1, never inside a band, so acc is final here.
                    if (commit) begin
                        band_reg <= i_hold_en ? held : acc_reg;
                    end
                end
            end

            assign o_bands[gi*MAG_W +: MAG_W] = band_reg;
        end
    endgenerate

endmodule

// File: tb/tb_fft_band_analyzer.sv
// Self-checking bench for fft_band_analyzer: sink framing scoreboard plus a
// frame-level band reference model built from a hand-derived band edge table.
module tb_fft_band_analyzer;

    localparam int DATA_W    = 16;
    localparam int FFT_LEN   = 512;
    localparam int NUM_BANDS = 16;
    localparam int MAG_W     = 16;

    logic                       i_clk;
    logic                       i_rst_n;
    logic                       i_sample_valid;
    logic [DATA_W-1:0]          i_sample;
    logic                       o_sample_ready;
    logic                       o_sink_valid;
    logic                       o_sink_sop;
    logic                       o_sink_eop;
    logic [DATA_W-1:0]          o_sink_real;
    logic                       i_sink_ready;
    logic                       i_src_valid;
    logic                       i_src_sop;
    logic                       i_src_eop;
    logic [DATA_W-1:0]          i_src_real;
    logic [DATA_W-1:0]          i_src_imag;
    logic                       o_src_ready;
    logic                       i_hold_en;
    logic                       i_err_clr;
    logic [NUM_BANDS*MAG_W-1:0] o_bands;
    logic                       o_frame_done;
    logic                       o_frame_err;

    fft_band_analyzer #(
        .DATA_W(DATA_W), .FFT_LEN(FFT_LEN), .NUM_BANDS(NUM_BANDS),
        .MAG_W(MAG_W), .DECAY_SHIFT(3)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_sample_valid(i_sample_valid), .i_sample(i_sample), .o_sample_ready(o_sample_ready),
        .o_sink_valid(o_sink_valid), .o_sink_sop(o_sink_sop), .o_sink_eop(o_sink_eop),
        .o_sink_real(o_sink_real), .i_sink_ready(i_sink_ready),
        .i_src_valid(i_src_valid), .i_src_sop(i_src_sop), .i_src_eop(i_src_eop),
        .i_src_real(i_src_real), .i_src_imag(i_src_imag), .o_src_ready(o_src_ready),
        .i_hold_en(i_hold_en), .i_err_clr(i_err_clr),
        .o_bands(o_bands), .o_frame_done(o_frame_done), .o_frame_err(o_frame_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Edges for FFT_LEN=512, NUM_BANDS=16: floor(2^(k/2)) made strictly increasing.
    int band_lo [0:NUM_BANDS] = '{1, 2, 3, 4, 5, 6, 8, 11, 16, 22, 32, 45, 64, 90, 128, 181, 256};

    logic [DATA_W-1:0] fr_re [FFT_LEN];
    logic [DATA_W-1:0] fr_im [FFT_LEN];
    int                model_bands [NUM_BANDS];
    int                sink_model_cnt;

    typedef struct {
        logic [DATA_W-1:0] d;
        bit                sop;
        bit                eop;
    } sink_item_t;
    sink_item_t sink_q [$];

    function automatic int ref_mag(input int re, input int im);
        int a, b, s;
        a = (re < 0) ? -re : re;
        b = (im < 0) ? -im : im;
        s = (a > b) ? a + b / 2 : b + a / 2;
        return (s > 65535) ? 65535 : s;
    endfunction

    function automatic void model_commit(input bit hold);
        for (int k = 0; k < NUM_BANDS; k++) begin
            int mx, dec;
            mx = 0;
            for (int b = band_lo[k]; b < band_lo[k+1]; b++) begin
                int m;
                m = ref_mag($signed(fr_re[b]), $signed(fr_im[b]));
                if (m > mx) mx = m;
            end
            dec = model_bands[k] - model_bands[k] / 8;
            model_bands[k] = (hold && dec > mx) ? dec : mx;
        end
    endfunction

    function automatic logic [NUM_BANDS*MAG_W-1:0] model_vec();
        logic [NUM_BANDS*MAG_W-1:0] v;
        for (int k = 0; k < NUM_BANDS; k++) v[k*MAG_W +: MAG_W] = MAG_W'(model_bands[k]);
        return v;
    endfunction

    function automatic void fill_frame(input int density_pct);
        for (int b = 0; b < FFT_LEN; b++) begin
            if ($urandom_range(99) < density_pct) begin
                fr_re[b] = DATA_W'($urandom);
                fr_im[b] = DATA_W'($urandom);
            end else begin
                fr_re[b] = '0;
                fr_im[b] = '0;
            end
        end
    endfunction

    // Drives bins first..last as consecutive beats; returns #1 after the final beat's edge.
    task automatic send_beats(input int first, input int last, input bit do_sop,
                              input bit eop_end, input bit clr_first);
        for (int b = first; b <= last; b++) begin
            i_src_valid = 1'b1;
            i_src_sop   = do_sop && (b == first);
            i_src_eop   = eop_end && (b == last);
            i_src_real  = fr_re[b];
            i_src_imag  = fr_im[b];
            i_err_clr   = clr_first && (b == first);
            @(posedge i_clk); #1;
        end
        i_err_clr = 1'b0;
    endtask

    task automatic src_idle();
        i_src_valid = 1'b0;
        i_src_sop   = 1'b0;
        i_src_eop   = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge i_clk);
        #1;
        total_cnt++;
        if (o_bands !== '0) $display("FAIL reset_bands: got %h want 0", o_bands); else pass_cnt++;
        total_cnt++;
        if ({o_sample_ready, o_sink_valid, o_src_ready, o_frame_done, o_frame_err} !== 5'b10100)
            $display("FAIL reset_flags: got rdy=%b sv=%b srdy=%b done=%b err=%b want 1 0 1 0 0",
                     o_sample_ready, o_sink_valid, o_src_ready, o_frame_done, o_frame_err);
        else pass_cnt++;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        i_sample_valid = 1'b1;
        i_sample       = 16'h1234;
        @(posedge i_clk); #1;
        i_sample_valid = 1'b0;
        total_cnt++;
        if (!(o_sink_valid === 1'b1 && o_sink_sop === 1'b1 && o_sink_eop === 1'b0 && o_sink_real === 16'h1234))
            $display("FAIL reset_first_sop: got v=%b sop=%b eop=%b d=%h want 1 1 0 1234",
                     o_sink_valid, o_sink_sop, o_sink_eop, o_sink_real);
        else pass_cnt++;
        @(posedge i_clk); #1;
        total_cnt++;
        if (o_sink_valid !== 1'b0) $display("FAIL reset_drain: got sink_valid=%b want 0", o_sink_valid);
        else pass_cnt++;
        sink_model_cnt = 1;
    endtask

    task automatic test_sink_stream(input int ncyc, input int valid_pct, input int ready_pct);
        bit                held_pending;
        logic [DATA_W-1:0] held_d;
        held_pending = 1'b0;
        held_d       = '0;
        for (int cyc = 0; cyc < ncyc + 4; cyc++) begin
            i_sample_valid = (cyc < ncyc) && ($urandom_range(99) < valid_pct);
            i_sample       = DATA_W'($urandom);
            i_sink_ready   = (cyc >= ncyc) || ($urandom_range(99) < ready_pct);
            @(negedge i_clk);
            total_cnt++;
            if (o_sample_ready !== (!o_sink_valid || i_sink_ready))
                $display("FAIL sink_ready_rule: got %b with sink_valid=%b sink_ready=%b",
                         o_sample_ready, o_sink_valid, i_sink_ready);
            else pass_cnt++;
            if (held_pending) begin
                total_cnt++;
                if (!(o_sink_valid === 1'b1 && o_sink_real === held_d))
                    $display("FAIL sink_stall_stable: got v=%b d=%h want 1 %h", o_sink_valid, o_sink_real, held_d);
                else pass_cnt++;
            end
            if (o_sink_valid && i_sink_ready) begin
                total_cnt++;
                if (sink_q.size() == 0) begin
                    $display("FAIL sink_unexpected: got d=%h with nothing outstanding", o_sink_real);
                end else begin
                    if (o_sink_real !== sink_q[0].d || o_sink_sop !== sink_q[0].sop || o_sink_eop !== sink_q[0].eop)
                        $display("FAIL sink_data: got d=%h sop=%b eop=%b want d=%h sop=%b eop=%b",
                                 o_sink_real, o_sink_sop, o_sink_eop, sink_q[0].d, sink_q[0].sop, sink_q[0].eop);
                    else pass_cnt++;
                    void'(sink_q.pop_front());
                end
            end
            held_pending = o_sink_valid && !i_sink_ready;
            held_d       = o_sink_real;
            if (i_sample_valid && o_sample_ready) begin
                sink_q.push_back('{d: i_sample, sop: (sink_model_cnt == 0), eop: (sink_model_cnt == FFT_LEN - 1)});
                sink_model_cnt = (sink_model_cnt + 1) % FFT_LEN;
            end
            @(posedge i_clk); #1;
        end
        total_cnt++;
        if (sink_q.size() != 0 || o_sink_valid !== 1'b0)
            $display("FAIL sink_lost: got %0d outstanding, sink_valid=%b want 0 0", sink_q.size(), o_sink_valid);
        else pass_cnt++;
        sink_q.delete();
    endtask

    task automatic test_single_bin();
        i_hold_en = 1'b0;
        fill_frame(0);
        fr_re[8] = 16'd1000;
        fr_im[8] = -16'sd400;
        send_beats(0, FFT_LEN - 1, 1'b1, 1'b1, 1'b0);
        model_commit(1'b0);
        total_cnt++;
        if (o_frame_done !== 1'b1) $display("FAIL single_bin_done: got %b want 1", o_frame_done); else pass_cnt++;
        total_cnt++;
        if (o_bands[6*MAG_W +: MAG_W] !== 16'd1200)
            $display("FAIL single_bin_band6: got %0d want 1200", o_bands[6*MAG_W +: MAG_W]);
        else pass_cnt++;
        total_cnt++;
        if (o_bands !== model_vec()) $display("FAIL single_bin_bands: got %h want %h", o_bands, model_vec());
        else pass_cnt++;
        src_idle();
        @(posedge i_clk); #1;
        total_cnt++;
        if (o_frame_done !== 1'b0) $display("FAIL single_bin_pulse: got done=%b want 0", o_frame_done); else pass_cnt++;
    endtask

    task automatic test_peak_hold();
        int want [3] = '{800, 700, 613};
        i_hold_en = 1'b0;
        fill_frame(0);
        send_beats(0, FFT_LEN - 1, 1'b1, 1'b1, 1'b0);
        model_commit(1'b0);
        src_idle();
        @(posedge i_clk); #1;
        i_hold_en = 1'b1;
        for (int f = 0; f < 3; f++) begin
            fill_frame(0);
            if (f == 0) fr_re[8] = 16'd800;
            send_beats(0, FFT_LEN - 1, 1'b1, 1'b1, 1'b0);
            model_commit(1'b1);
            total_cnt++;
            if (o_frame_done !== 1'b1 || o_bands[6*MAG_W +: MAG_W] !== MAG_W'(want[f]))
                $display("FAIL peak_hold_frame%0d: got done=%b band6=%0d want 1 %0d",
                         f, o_frame_done, o_bands[6*MAG_W +: MAG_W], want[f]);
            else pass_cnt++;
            total_cnt++;
            if (o_bands !== model_vec()) $display("FAIL peak_hold_bands%0d: got %h want %h", f, o_bands, model_vec());
            else pass_cnt++;
            src_idle();
            @(posedge i_clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 4; f++) begin
            bit hold;
            hold      = $urandom_range(1);
            i_hold_en = hold;
            fill_frame(f == 0 ? 100 : 30);
            fr_re[20] = 16'h8000;
            fr_im[20] = (f == 1) ? 16'h8000 : 16'h0000;
            send_beats(0, FFT_LEN - 1, 1'b1, 1'b1, 1'b0);
            model_commit(hold);
            total_cnt++;
            if (o_frame_done !== 1'b1 || o_bands !== model_vec())
                $display("FAIL b2b_frame%0d: got done=%b bands=%h want 1 %h", f, o_frame_done, o_bands, model_vec());
            else pass_cnt++;
        end
        src_idle();
        @(posedge i_clk); #1;
        total_cnt++;
        if (o_frame_done !== 1'b0) $display("FAIL b2b_pulse: got done=%b want 0", o_frame_done); else pass_cnt++;
    endtask

    task automatic test_eop_error();
        i_hold_en = 1'b0;
        fill_frame(50);
        send_beats(0, 300, 1'b1, 1'b1, 1'b0);
        src_idle();
        total_cnt++;
        if (o_frame_done !== 1'b0 || o_frame_err !== 1'b1)
            $display("FAIL eop_err_flag: got done=%b err=%b want 0 1", o_frame_done, o_frame_err);
        else pass_cnt++;
        repeat (3) @(posedge i_clk);
        #1;
        total_cnt++;
        if (o_bands !== model_vec() || o_frame_err !== 1'b1)
            $display("FAIL eop_err_hold: got err=%b bands=%h want 1 %h", o_frame_err, o_bands, model_vec());
        else pass_cnt++;
        i_err_clr = 1'b1;
        @(posedge i_clk); #1;
        i_err_clr = 1'b0;
        total_cnt++;
        if (o_frame_err !== 1'b0) $display("FAIL eop_err_clear: got %b want 0", o_frame_err); else pass_cnt++;
        fill_frame(50);
        send_beats(0, FFT_LEN - 1, 1'b1, 1'b1, 1'b0);
        model_commit(1'b0);
        src_idle();
        total_cnt++;
        if (o_frame_done !== 1'b1 || o_bands !== model_vec())
            $display("FAIL eop_err_recover: got done=%b bands=%h want 1 %h", o_frame_done, o_bands, model_vec());
        else pass_cnt++;
    endtask

    task automatic test_sop_midframe();
        i_hold_en = 1'b1;
        fill_frame(40);
        send_beats(0, 99, 1'b1, 1'b0, 1'b0);
        // New SOP with a simultaneous clear: the error must still latch, and this frame must commit.
        fill_frame(40);
        send_beats(0, FFT_LEN - 1, 1'b1, 1'b1, 1'b1);
        model_commit(1'b1);
        src_idle();
        total_cnt++;
        if (o_frame_err !== 1'b1) $display("FAIL sop_mid_err: got %b want 1", o_frame_err); else pass_cnt++;
        total_cnt++;
        if (o_frame_done !== 1'b1 || o_bands !== model_vec())
            $display("FAIL sop_mid_commit: got done=%b bands=%h want 1 %h", o_frame_done, o_bands, model_vec());
        else pass_cnt++;
        i_err_clr = 1'b1;
        @(posedge i_clk); #1;
        i_err_clr = 1'b0;
    endtask

    task automatic test_wrap_error();
        i_hold_en = 1'b0;
        fill_frame(40);
        send_beats(0, FFT_LEN - 1, 1'b1, 1'b0, 1'b0);
        src_idle();
        total_cnt++;
        if (o_frame_err !== 1'b1 || o_frame_done !== 1'b0 || o_bands !== model_vec())
            $display("FAIL wrap_err: got err=%b done=%b bands=%h want 1 0 %h",
                     o_frame_err, o_frame_done, o_bands, model_vec());
        else pass_cnt++;
        i_err_clr = 1'b1;
        @(posedge i_clk); #1;
        i_err_clr = 1'b0;
    endtask

    task automatic test_reset_midframe();
        i_hold_en = 1'b1;
        fill_frame(60);
        send_beats(0, 199, 1'b1, 1'b0, 1'b0);
        src_idle();
        i_rst_n = 1'b0;
        #2;
        total_cnt++;
        if (o_bands !== '0 || o_frame_done !== 1'b0 || o_frame_err !== 1'b0)
            $display("FAIL reset_mid_clear: got bands=%h done=%b err=%b want 0 0 0", o_bands, o_frame_done, o_frame_err);
        else pass_cnt++;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        for (int k = 0; k < NUM_BANDS; k++) model_bands[k] = 0;
        sink_model_cnt = 0;
        fill_frame(60);
        send_beats(0, FFT_LEN - 1, 1'b1, 1'b1, 1'b0);
        model_commit(1'b1);
        src_idle();
        total_cnt++;
        if (o_frame_done !== 1'b1 || o_bands !== model_vec() || o_frame_err !== 1'b0)
            $display("FAIL reset_mid_recover: got done=%b err=%b bands=%h want 1 0 %h",
                     o_frame_done, o_frame_err, o_bands, model_vec());
        else pass_cnt++;
    endtask

    initial begin
        i_rst_n        = 1'b0;
        i_sample_valid = 1'b0;
        i_sample       = '0;
        i_sink_ready   = 1'b1;
        i_src_valid    = 1'b0;
        i_src_sop      = 1'b0;
        i_src_eop      = 1'b0;
        i_src_real     = '0;
        i_src_imag     = '0;
        i_hold_en      = 1'b0;
        i_err_clr      = 1'b0;
        sink_model_cnt = 0;
        for (int k = 0; k < NUM_BANDS; k++) model_bands[k] = 0;

        test_reset();
        test_sink_stream(FFT_LEN + 2, 100, 100);
        test_sink_stream(600, 70, 50);
        test_single_bin();
        test_peak_hold();
        test_back_to_back();
        test_eop_error();
        test_sop_midframe();
        test_wrap_error();
        test_reset_midframe();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
